// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction-memory request at a time from the PC
// and buffers returned words with their addresses in a small FIFO toward decode.
module instr_fetch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        input_clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        pc_hold,
    input  logic        halt,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q[FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // The request is masked during reset so memory never sees a grantable request there
    assign imem_req  = (state_q == REQ) && !reset;
    assign imem_addr = pc_in;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!halt && !flush && (count_q < CW'(FIFO_DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = imem_gnt ? DROP : IDLE;
                end else if (imem_gnt) begin
                    req_pc_d = pc_in;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                // A flush here only re-targets the PC; the orphaned word still has to drain
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        next_pc = pc_in;
        pc_hold = 1'b1;
        if (reset) begin
            next_pc = pc_in;
            pc_hold = 1'b1;
        end else if (flush) begin
            next_pc = flush_target;
            pc_hold = 1'b0;
        end else if (imem_req && imem_gnt) begin
            next_pc = pc_in + 32'd4;
            pc_hold = 1'b0;
        end
    end

    assign dec_valid = (count_q != '0);
    assign dec_instr = fifo_instr_q[rd_ptr_q];
    assign dec_pc    = fifo_pc_q[rd_ptr_q];
    assign pop       = dec_valid && dec_ready;

    always_ff @(posedge input_clock) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it
    always_ff @(posedge input_clock) begin
        if (!reset && push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: acts as PC register and instruction memory, and checks decode
// output against a transaction-level queue model of fetched (pc, word) pairs.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        input_clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] next_pc;
    logic        pc_hold;
    logic        halt = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;

    instr_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .input_clock (input_clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .next_pc     (next_pc),
        .pc_hold     (pc_hold),
        .halt        (halt),
        .flush       (flush),
        .flush_target(flush_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
    );

    always #5 input_clock = ~input_clock;

    int tests = 0;
    int failed = 0;
    int gnt_pct, rv_pct, flush_pct, halt_pct, rdy_pct;
    int n_gnt = 0;
    int n_pop = 0;
    logic [31:0] pc = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] mem_addr = '0;
    bit mem_pend = 0;
    bit mem_live = 0;
    bit armed = 0;
    bit prev_req = 0;
    bit prev_ok = 0;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] s_next;
    logic        s_hold;
    logic        s_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic knobs(input int g, input int r, input int f, input int h, input int d);
        gnt_pct = g; rv_pct = r; flush_pct = f; halt_pct = h; rdy_pct = d;
    endtask

    // Inputs for the coming cycle; callers may override afterwards
    task automatic drive();
        reset        = 1'b0;
        pc_in        = pc;
        imem_gnt     = int'($urandom_range(99)) < gnt_pct;
        imem_rvalid  = mem_pend && (int'($urandom_range(99)) < rv_pct);
        imem_rdata   = imem_rvalid ? mem_word(mem_addr) : 32'h0;
        flush        = int'($urandom_range(99)) < flush_pct;
        flush_target = $urandom() & 32'hFFFF_FFFC;
        halt         = int'($urandom_range(99)) < halt_pct;
        dec_ready    = int'($urandom_range(99)) < rdy_pct;
    endtask

    task automatic settle();
        logic [31:0] e_np;
        logic        e_h;
        @(negedge input_clock);
        if (reset)                       begin e_np = pc_in;        e_h = 1'b1; end
        else if (flush)                  begin e_np = flush_target; e_h = 1'b0; end
        else if (imem_req && imem_gnt)   begin e_np = pc_in + 32'd4; e_h = 1'b0; end
        else                             begin e_np = pc_in;        e_h = 1'b1; end
        chk("next_pc", next_pc, e_np);
        chk("pc_hold", pc_hold, e_h);
        if (armed) begin
            chk("one_outstanding", imem_req && mem_pend, 1'b0);
            if (imem_req) chk("imem_addr", imem_addr, pc);
            if (imem_req && !prev_req) chk("issue_rule", prev_ok, 1'b1);
            chk("dec_valid", dec_valid, q_pc.size() != 0);
            if (dec_valid && q_pc.size() != 0) begin
                chk("dec_pc", dec_pc, q_pc[0]);
                chk("dec_instr", dec_instr, q_ins[0]);
            end
            if (dec_valid && dec_ready && !flush && !reset) chk("pc_order", dec_pc, exp_pc);
        end
        s_next = next_pc;
        s_hold = pc_hold;
        s_req  = imem_req;
    endtask

    task automatic advance();
        bit ok;
        ok = !halt && !flush && !reset && (q_pc.size() < DEPTH);
        @(posedge input_clock);
        if (reset) begin
            q_pc.delete(); q_ins.delete();
            mem_pend = 0; mem_live = 0; armed = 1;
        end else begin
            if (flush) begin
                q_pc.delete(); q_ins.delete();
            end else begin
                if (q_pc.size() != 0 && dec_ready) begin
                    void'(q_pc.pop_front()); void'(q_ins.pop_front());
                    n_pop++;
                    exp_pc = exp_pc + 32'd4;
                end
                if (imem_rvalid && mem_live) begin
                    q_pc.push_back(mem_addr);
                    q_ins.push_back(imem_rdata);
                    chk("fifo_bound", q_pc.size() <= DEPTH, 1'b1);
                end
            end
            if (imem_rvalid) mem_pend = 0;
            if (flush) mem_live = 0;
            if (s_req && imem_gnt) begin
                mem_pend = 1; mem_addr = pc; mem_live = !flush; n_gnt++;
            end
            if (flush) exp_pc = flush_target;
        end
        pc = s_hold ? pc : s_next;
        if (reset) exp_pc = pc;
        prev_req = s_req;
        prev_ok  = ok;
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive();
            reset = 1'b1;
            flush = 1'b0;
            settle();
            advance();
        end
        n_gnt = 0;
    endtask

    task automatic wait_pend(input string tag);
        for (int i = 0; i < 20 && !mem_pend; i++) begin
            drive(); settle(); advance();
        end
        chk(tag, mem_pend, 1'b1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(); settle();
            if (imem_req) begin
                found = 1;
                chk(tag, imem_addr, exp_addr);
            end
            advance();
        end
        chk({tag, "_seen"}, found, 1'b1);
    endtask

    initial begin
        bit done;
        #1;
        // Best-case fetch latency from reset
        knobs(100, 100, 0, 0, 0);
        pc = 32'h0;
        do_reset();
        drive(); settle();
        chk("c0_req", imem_req, 1'b0);
        chk("c0_valid", dec_valid, 1'b0);
        advance();
        drive(); settle();
        chk("c1_req", imem_req, 1'b1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_next_pc", next_pc, 32'h4);
        chk("c1_pc_hold", pc_hold, 1'b0);
        advance();
        drive(); settle();
        chk("c2_rdata", imem_rdata, 32'h2008_0005);
        chk("c2_valid", dec_valid, 1'b0);
        advance();
        drive(); settle();
        chk("c3_valid", dec_valid, 1'b1);
        chk("c3_pc", dec_pc, 32'h0);
        chk("c3_instr", dec_instr, 32'h2008_0005);
        advance();

        // Decode stalled: FIFO fills with two fetches, then issue stops
        repeat (10) begin drive(); settle(); advance(); end
        drive(); settle();
        chk("full_grants", n_gnt, 32'd2);
        chk("full_no_req", imem_req, 1'b0);
        chk("full_head_pc", dec_pc, 32'h0);
        advance();

        // Flush while waiting: late word dropped, refetch from target
        knobs(100, 0, 0, 0, 100);
        do_reset();
        wait_pend("wait_reached");
        drive();
        flush = 1'b1;
        flush_target = 32'h0000_0040;
        settle(); advance();
        knobs(0, 0, 0, 0, 100);
        repeat (3) begin
            drive(); settle();
            chk("drop_no_req", imem_req, 1'b0);
            advance();
        end
        knobs(100, 100, 0, 0, 100);
        drive(); settle(); advance();
        drive(); settle();
        chk("drop_empty", dec_valid, 1'b0);
        advance();
        wait_req("refetch_addr", 32'h0000_0040);

        // Halt during WAIT: in-flight word still lands, no new issue
        knobs(100, 0, 0, 0, 0);
        pc = 32'h0;
        do_reset();
        wait_pend("halt_wait_reached");
        knobs(100, 100, 0, 100, 0);
        drive(); settle(); advance();
        repeat (5) begin
            drive(); settle();
            chk("halt_no_req", imem_req, 1'b0);
            advance();
        end
        drive(); settle();
        chk("halt_pushed", dec_valid, 1'b1);
        chk("halt_pushed_pc", dec_pc, 32'h0);
        advance();
        knobs(100, 100, 0, 0, 0);
        wait_req("halt_release", 32'h4);

        // PC wrap on grant
        knobs(100, 0, 0, 0, 0);
        pc = 32'hFFFF_FFFC;
        do_reset();
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            drive(); settle();
            if (imem_req) begin
                done = 1;
                chk("wrap_next_pc", next_pc, 32'h0);
                chk("wrap_hold", pc_hold, 1'b0);
            end
            advance();
        end
        chk("wrap_seen", done, 1'b1);

        // Reset during WAIT with one entry buffered
        knobs(100, 100, 0, 0, 0);
        pc = 32'h0;
        do_reset();
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive();
            if (mem_pend && q_pc.size() == 1) begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
                reset       = 1'b1;
                done        = 1;
            end
            settle(); advance();
        end
        chk("rst_wait_reached", done, 1'b1);
        drive(); settle();
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        advance();
        wait_req("rst_refetch", pc);

        // Randomized traffic against the queue model
        knobs(60, 50, 5, 15, 60);
        do_reset();
        n_pop = 0;
        repeat (3000) begin drive(); settle(); advance(); end
        chk("random_progress", n_pop > 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the number of fetched-instruction entries buffered toward decode; legal values are powers of two, 2 or more.
REQ-002 input_clock  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 pc_in  in  32  SHALL be the current program-counter value (PC register output).
REQ-005 next_pc  out  32  SHALL be the PC register's next-address input.
REQ-006 pc_hold  out  1  SHALL drive the PC register's halt input; high = PC keeps its value.
REQ-007 halt  in  1  SHALL be the global halt; high blocks issue of new fetches.
REQ-008 flush  in  1  SHALL be the branch/jump redirect strobe, one cycle.
REQ-009 flush_target  in  32  SHALL be the redirect address, valid when flush=1.
REQ-010 imem_req/imem_addr  out  1/32  SHALL be the instruction-memory request and word address.
REQ-011 imem_gnt  in  1  SHALL mark request acceptance in a cycle where imem_req=1.
REQ-012 imem_rvalid/imem_rdata  in  1/32  SHALL return one instruction word per accepted request, no earlier than the cycle after grant.
REQ-013 dec_valid/dec_instr/dec_pc  out  1/32/32  SHALL present the FIFO head entry to decode.
REQ-014 dec_ready  in  1  SHALL mark decode acceptance; transfer when dec_valid and dec_ready are both high.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one memory request outstanding.
REQ-016 IDLE->REQ SHALL occur when halt=0, flush=0, and FIFO count < FIFO_DEPTH; otherwise stay IDLE.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc_in; pc_in is stable because the PC only moves on grant or flush.
REQ-018 REQ with imem_gnt=1, flush=0 SHALL capture pc_in into req_pc and go to WAIT.
REQ-019 REQ with flush=1 SHALL go to DROP if imem_gnt=1, else to IDLE (request withdrawn).
REQ-020 WAIT with imem_rvalid=1, flush=0 SHALL push {req_pc, imem_rdata} into the FIFO and go to IDLE.
REQ-021 WAIT with flush=1 SHALL go to IDLE if imem_rvalid=1 (word discarded), else to DROP.
REQ-022 DROP SHALL discard the next imem_rvalid word and then go to IDLE; flush in DROP keeps DROP.
REQ-023 next_pc/pc_hold (combinational): flush=1 -> flush_target/0; else REQ&&imem_gnt -> pc_in+4 (mod 2^32, 0xFFFFFFFC wraps to 0)/0; else pc_in/1.
REQ-024 halt SHALL NOT abort a fetch already in REQ or WAIT; that fetch completes normally.
REQ-025 FIFO: dec_valid=(count!=0); pop on dec_valid&&dec_ready; simultaneous push and pop SHALL keep count unchanged; entries leave in push order.
REQ-026 Flush SHALL empty the FIFO on the same edge, overriding any push or pop in that cycle; dec_valid=0 on the next cycle.
REQ-027 Push to a full FIFO SHALL never occur; the issue condition in REQ-016 guarantees space.
REQ-028 Best-case timing: IDLE at cycle 0, imem_req at cycle 1 with grant, rvalid at cycle 2, dec_valid at cycle 3.

Reset
REQ-029 reset SHALL force state IDLE, FIFO count and pointers 0, req_pc 0, dec_valid 0, and imem_req 0 on the next edge.
REQ-030 During reset, pc_hold SHALL be 1 and next_pc SHALL equal pc_in.
REQ-031 Reset mid-transaction SHALL abandon any outstanding fetch; instruction memory shares this reset and returns no stale word.

Verification
REQ-032 Release reset with pc_in=0, imem_gnt=1, and rdata=0x20080005 one cycle after grant -> dec_valid=1, dec_pc=0, dec_instr=0x20080005 at cycle 3; next_pc=4, pc_hold=0 in the grant cycle.
REQ-033 Hold dec_ready=0 with FIFO_DEPTH=2 -> exactly two fetches (pc 0, 4) complete; imem_req stays 0 afterward.
REQ-034 Assert flush with target 0x00000040 in WAIT before rvalid -> DROP discards the late word; FIFO is empty; next fetch has imem_addr=0x40.
REQ-035 Assert halt while in WAIT -> the in-flight word is pushed; no new imem_req until halt=0.
REQ-036 Grant with pc_in=0xFFFFFFFC -> next_pc=0x00000000.
REQ-037 Assert reset during WAIT with FIFO count=1 -> dec_valid=0, imem_req=0 on the next cycle; a fresh fetch is issued after release.
